// File: rtl/reu_dma_sequencer.sv
// Block-transfer engine for the REU: COPY, FILL, VERIFY and SWAP over len words,
// issuing one access at a time to the shared memory arbitrator via a toggle req/ack handshake.
module reu_dma_sequencer #(
  parameter int unsigned abits = 24,
  parameter int unsigned dbits = 8,
  parameter int unsigned lbits = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [abits-1:0] src_a,
  input  logic [abits-1:0] dst_a,
  input  logic [lbits-1:0] len,
  input  logic             src_fix,
  input  logic             dst_fix,
  input  logic [dbits-1:0] fill_d,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [abits-1:0] cur_src,
  output logic [abits-1:0] cur_dst,
  output logic [lbits-1:0] remaining,
  output logic             m_req,
  input  logic             m_ack,
  output logic             m_we,
  output logic [abits-1:0] m_a,
  output logic [dbits-1:0] m_d,
  input  logic [dbits-1:0] m_q
);

  localparam logic [1:0] OP_COPY   = 2'b00;
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_VERIFY = 2'b10;
  localparam logic [1:0] OP_SWAP   = 2'b11;

  typedef enum logic [2:0] {IDLE, RD_SRC, RD_DST, WR_DST, WR_SRC, ADV, FIN} state_t;

  state_t           state;
  logic [1:0]       op_r;
  logic             src_fix_r;
  logic             dst_fix_r;
  logic [dbits-1:0] fill_r;
  logic [dbits-1:0] a_r;
  logic [dbits-1:0] b_r;
  logic [abits-1:0] src_nx;
  logic [abits-1:0] dst_nx;
  logic             acked;

  // Post-advance addresses, so the next word's first access can issue on the ADV exit edge.
  assign src_nx = cur_src + abits'(!src_fix_r);
  assign dst_nx = cur_dst + abits'(!dst_fix_r);
  assign acked  = (m_ack == m_req);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      op_r      <= OP_COPY;
      src_fix_r <= 1'b0;
      dst_fix_r <= 1'b0;
      fill_r    <= '0;
      a_r       <= '0;
      b_r       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_a       <= '0;
      m_d       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_r      <= op;
            src_fix_r <= src_fix;
            dst_fix_r <= dst_fix;
            fill_r    <= fill_d;
            cur_src   <= src_a;
            cur_dst   <= dst_a;
            remaining <= len;
            busy      <= 1'b1;
            mismatch  <= 1'b0;
            m_req     <= ~m_req;
            if (op == OP_FILL) begin
              state <= WR_DST;
              m_we  <= 1'b1;
              m_a   <= dst_a;
              m_d   <= fill_d;
            end else begin
              state <= RD_SRC;
              m_we  <= 1'b0;
              m_a   <= src_a;
            end
          end
        end
        RD_SRC: begin
          if (acked) begin
            a_r   <= m_q;
            m_req <= ~m_req;
            m_a   <= cur_dst;
            if (op_r == OP_COPY) begin
              state <= WR_DST;
              m_we  <= 1'b1;
              m_d   <= m_q;
            end else begin
              state <= RD_DST;
              m_we  <= 1'b0;
            end
          end
        end
        RD_DST: begin
          if (acked) begin
            b_r <= m_q;
            if (op_r == OP_VERIFY) begin
              // A failing word leaves the addresses and count pointing at it.
              if (m_q != a_r) begin
                mismatch <= 1'b1;
                done     <= 1'b1;
                state    <= FIN;
              end else begin
                state <= ADV;
              end
            end else begin
              state <= WR_DST;
              m_req <= ~m_req;
              m_we  <= 1'b1;
              m_a   <= cur_dst;
              m_d   <= a_r;
            end
          end
        end
        WR_DST: begin
          if (acked) begin
            if (op_r == OP_SWAP) begin
              state <= WR_SRC;
              m_req <= ~m_req;
              m_we  <= 1'b1;
              m_a   <= cur_src;
              m_d   <= b_r;
            end else begin
              state <= ADV;
            end
          end
        end
        WR_SRC: begin
          if (acked) state <= ADV;
        end
        ADV: begin
          cur_src   <= src_nx;
          cur_dst   <= dst_nx;
          remaining <= remaining - lbits'(1);
          if (remaining == lbits'(1)) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            m_req <= ~m_req;
            if (op_r == OP_FILL) begin
              state <= WR_DST;
              m_we  <= 1'b1;
              m_a   <= dst_nx;
              m_d   <= fill_r;
            end else begin
              state <= RD_SRC;
              m_we  <= 1'b0;
              m_a   <= src_nx;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reu_dma_sequencer.sv
// Scoreboard bench for reu_dma_sequencer: a memory slave with optional random ack delay,
// a reference model that predicts every access and the final register state.
module tb_reu_dma_sequencer;

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 4;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } acc_t;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [1:0]    op;
  logic [AW-1:0] src_a, dst_a;
  logic [LW-1:0] len;
  logic          src_fix, dst_fix;
  logic [DW-1:0] fill_d;
  logic          busy, done, mismatch;
  logic [AW-1:0] cur_src, cur_dst;
  logic [LW-1:0] remaining;
  logic          m_req, m_ack, m_we;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d, m_q;

  reu_dma_sequencer #(.abits(AW), .dbits(DW), .lbits(LW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .src_a(src_a), .dst_a(dst_a), .len(len), .src_fix(src_fix), .dst_fix(dst_fix),
    .fill_d(fill_d), .busy(busy), .done(done), .mismatch(mismatch),
    .cur_src(cur_src), .cur_dst(cur_dst), .remaining(remaining),
    .m_req(m_req), .m_ack(m_ack), .m_we(m_we), .m_a(m_a), .m_d(m_d), .m_q(m_q)
  );

  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] mdl [logic [AW-1:0]];
  acc_t          exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;
  int max_wait = 0;
  int cur_wait = 0;
  int wcnt     = 0;
  bit mon_en   = 1'b0;
  int last_acc;

  logic [AW-1:0] e_src, e_dst;
  logic [LW-1:0] e_rem;
  logic          e_mis;
  int            e_cyc;
  int            e_nacc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] mrd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [DW-1:0] drd(input logic [AW-1:0] a);
    return mdl.exists(a) ? mdl[a] : 8'h00;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    mem[a] = v;
    mdl[a] = v;
  endtask

  // Memory slave: acks after cur_wait extra cycles, read data valid with the ack
  always @(posedge clk) begin
    if (!reset_n) begin
      m_ack    <= 1'b0;
      m_q      <= '0;
      wcnt     <= 0;
      cur_wait <= 0;
    end else if (m_req != m_ack) begin
      if (wcnt >= cur_wait) begin
        if (m_we) mem[m_a] = m_d;
        else m_q <= mrd(m_a);
        m_ack    <= m_req;
        wcnt     <= 0;
        cur_wait <= $urandom_range(0, max_wait);
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // Monitor: every req toggle is popped against the predicted access; descriptor held while pending
  logic        prev_pend = 1'b0;
  logic        prev_req  = 1'b0;
  logic [33:0] prev_desc = '0;
  always @(negedge clk) begin
    acc_t e;
    if (!mon_en || !reset_n) begin
      prev_pend = 1'b0;
      prev_req  = m_req;
    end else begin
      if (prev_pend) check("desc_stable", 64'({m_req, m_we, m_a, m_d}), 64'(prev_desc));
      if (m_req != prev_req) begin
        n_acc++;
        if (exp_q.size() == 0) check("unexpected_access", 64'({m_we, m_a}), 64'(0));
        else begin
          e = exp_q.pop_front();
          check("access", 64'({m_we, m_a, (m_we ? m_d : 8'h00)}), 64'(e));
        end
      end
      prev_req  = m_req;
      prev_pend = (m_req != m_ack);
      prev_desc = {m_req, m_we, m_a, m_d};
    end
  end

  task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    acc_t e;
    e.we = we;
    e.a  = a;
    e.d  = d;
    exp_q.push_back(e);
    e_nacc++;
  endtask

  // Reference model: predicted accesses, final registers, and zero-wait done cycle
  task automatic model(input logic [1:0] mop, input logic [AW-1:0] s, input logic [AW-1:0] d,
                       input logic [LW-1:0] ln, input logic sf, input logic df, input logic [DW-1:0] fv);
    logic [DW-1:0] a, b;
    int n;
    n      = (ln == 0) ? (1 << LW) : int'(ln);
    e_src  = s;
    e_dst  = d;
    e_rem  = ln;
    e_mis  = 1'b0;
    e_cyc  = 1;
    e_nacc = 0;
    for (int i = 0; i < n; i++) begin
      case (mop)
        2'b00: begin
          a = drd(e_src);
          push(1'b0, e_src, 8'h00);
          push(1'b1, e_dst, a);
          mdl[e_dst] = a;
          e_cyc += 5;
        end
        2'b01: begin
          push(1'b1, e_dst, fv);
          mdl[e_dst] = fv;
          e_cyc += 3;
        end
        2'b10: begin
          a = drd(e_src);
          b = drd(e_dst);
          push(1'b0, e_src, 8'h00);
          push(1'b0, e_dst, 8'h00);
          if (a != b) begin
            e_mis = 1'b1;
            e_cyc += 4;
            return;
          end
          e_cyc += 5;
        end
        default: begin
          a = drd(e_src);
          b = drd(e_dst);
          push(1'b0, e_src, 8'h00);
          push(1'b0, e_dst, 8'h00);
          push(1'b1, e_dst, a);
          mdl[e_dst] = a;
          push(1'b1, e_src, b);
          mdl[e_src] = b;
          e_cyc += 9;
        end
      endcase
      if (!sf) e_src = e_src + 24'd1;
      if (!df) e_dst = e_dst + 24'd1;
      e_rem = e_rem - 4'd1;
    end
  endtask

  task automatic drive(input logic [1:0] mop, input logic [AW-1:0] s, input logic [AW-1:0] d,
                       input logic [LW-1:0] ln, input logic sf, input logic df, input logic [DW-1:0] fv);
    op = mop; src_a = s; dst_a = d; len = ln; src_fix = sf; dst_fix = df; fill_d = fv;
    start = 1'b1;
  endtask

  task automatic run(input logic [1:0] mop, input logic [AW-1:0] s, input logic [AW-1:0] d,
                     input logic [LW-1:0] ln, input logic sf, input logic df, input logic [DW-1:0] fv,
                     input bit chk_cyc, input bit noise);
    int cyc;
    int acc0;
    model(mop, s, d, ln, sf, df, fv);
    acc0 = n_acc;
    @(negedge clk);
    drive(mop, s, d, ln, sf, df, fv);
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        check("busy_after_start", 64'(busy), 64'(1));
        check("mismatch_cleared", 64'(mismatch), 64'(0));
      end
      if (done) break;
      if (noise && $urandom_range(0, 3) == 0)
        drive(2'($urandom), 24'($urandom), 24'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    end
    start = 1'b0;
    last_acc = n_acc - acc0;
    check("done_seen", 64'(done), 64'(1));
    if (chk_cyc) check("done_cycle", 64'(cyc), 64'(e_cyc));
    check("cur_src", 64'(cur_src), 64'(e_src));
    check("cur_dst", 64'(cur_dst), 64'(e_dst));
    check("remaining", 64'(remaining), 64'(e_rem));
    check("mismatch", 64'(mismatch), 64'(e_mis));
    check("busy_with_done", 64'(busy), 64'(1));
    check("access_count", 64'(last_acc), 64'(e_nacc));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'(0));
    check("busy_cleared", 64'(busy), 64'(0));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ctl"}, 64'({busy, done, mismatch, m_req, m_we}), 64'(0));
    check({tag, "_m_a"}, 64'(m_a), 64'(0));
    check({tag, "_m_d"}, 64'(m_d), 64'(0));
    check({tag, "_addr"}, 64'({cur_src, cur_dst}), 64'(0));
    check({tag, "_rem"}, 64'(remaining), 64'(0));
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    src_a   = '0;
    dst_a   = '0;
    len     = '0;
    src_fix = 1'b0;
    dst_fix = 1'b0;
    fill_d  = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // COPY 4 words, zero-wait
    for (int i = 0; i < 4; i++) preload(24'h000010 + 24'(i), 8'(8'h11 * (i + 1)));
    run(2'b00, 24'h000010, 24'h020000, 4'd4, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("copy_done_cycle", 64'(e_cyc), 64'(21));
    check("copy_nacc", 64'(last_acc), 64'(8));
    check("copy_cur_src", 64'(cur_src), 64'(24'h000014));
    for (int i = 0; i < 4; i++) check("copy_mem", 64'(mrd(24'h020000 + 24'(i))), 64'(8'(8'h11 * (i + 1))));

    // FILL with fixed destination
    run(2'b01, 24'h000000, 24'h000100, 4'd3, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
    check("fill_cur_dst", 64'(cur_dst), 64'(24'h000100));
    check("fill_mem", 64'(mrd(24'h000100)), 64'(8'hA5));
    check("fill_nacc", 64'(last_acc), 64'(3));

    // VERIFY with a difference at word 2
    for (int i = 0; i < 5; i++) begin
      preload(24'h000300 + 24'(i), 8'(8'h10 + i));
      preload(24'h000400 + 24'(i), (i == 2) ? 8'hEE : 8'(8'h10 + i));
    end
    run(2'b10, 24'h000300, 24'h000400, 4'd5, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("verify_mismatch", 64'(mismatch), 64'(1));
    check("verify_cur_src", 64'(cur_src), 64'(24'h000302));
    check("verify_remaining", 64'(remaining), 64'(3));
    check("verify_reads", 64'(last_acc), 64'(6));

    // SWAP two words (its start also clears the sticky mismatch)
    preload(24'h000500, 8'h01); preload(24'h000501, 8'h02);
    preload(24'h000600, 8'hF1); preload(24'h000601, 8'hF2);
    run(2'b11, 24'h000500, 24'h000600, 4'd2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("swap_src0", 64'(mrd(24'h000500)), 64'(8'hF1));
    check("swap_src1", 64'(mrd(24'h000501)), 64'(8'hF2));
    check("swap_dst0", 64'(mrd(24'h000600)), 64'(8'h01));
    check("swap_dst1", 64'(mrd(24'h000601)), 64'(8'h02));

    // len=0 runs 16 words; source wraps through the top of the address space
    for (int i = 0; i < 16; i++) preload(24'hFFFFFE + 24'(i), 8'(8'h40 + i));
    run(2'b00, 24'hFFFFFE, 24'h000800, 4'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("wrap_nacc", 64'(last_acc), 64'(32));
    check("wrap_cur_src", 64'(cur_src), 64'(24'h00000E));
    check("wrap_mem", 64'(mrd(24'h000801)), 64'(8'h41));

    // Random ack delays with start pulses while busy
    for (int a = 24'h1000; a < 24'h2000; a++) preload(24'(a), 8'($urandom));
    max_wait = 5;
    for (int k = 0; k < 8; k++)
      run(2'(k), 24'h001000 + 24'($urandom_range(0, 255)), 24'h001800 + 24'($urandom_range(0, 255)),
          4'($urandom_range(1, 6)), 1'($urandom), 1'($urandom), 8'($urandom), 1'b0, 1'b1);

    // Reset in the middle of a SWAP aborts with no done pulse
    model(2'b11, 24'h002000, 24'h002100, 4'd3, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    drive(2'b11, 24'h002000, 24'h002100, 4'd3, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_state("midreset");
    reset_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_done_after_reset", 64'({done, busy}), 64'(0));
    end
    mon_en   = 1'b1;
    max_wait = 0;
    @(negedge clk);

    // Engine recovers after the abort
    run(2'b01, 24'h000000, 24'h003000, 4'd2, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0);
    check("post_reset_fill", 64'(mrd(24'h003001)), 64'(8'h5A));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reu_dma_sequencer.md
# reu_dma_sequencer

Block-transfer engine acting as one master on the shared memory arbitrator, using the same toggle req/ack handshake. It executes COPY, FILL, VERIFY and SWAP over a block of `len` words, with a source and a destination address that each increment or stay fixed. The REU register front-end drives it, and it serves as the C64-side and expansion-RAM DMA sequencer.

## Interface
- `abits`, 24, address width of the memory port and of the address registers.
- `dbits`, 8, data word width.
- `lbits`, 16, transfer length width; `len`=0 encodes 2^lbits words.

- `clk`  in  1  single clock, all logic on rising edge.
- `reset_n`  in  1  synchronous reset, active-low.
- `start`  in  1  one-cycle command strobe; sampled only while idle.
- `op`  in  2  00 COPY, 01 FILL, 10 VERIFY, 11 SWAP.
- `src_a`, `dst_a`  in  abits  start addresses.
- `len`  in  lbits  word count.
- `src_fix`, `dst_fix`  in  1  1 = hold that address constant.
- `fill_d`  in  dbits  FILL pattern.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle pulse at command end.
- `mismatch`  out  1  sticky VERIFY failure flag; cleared by the next accepted `start`.
- `cur_src`, `cur_dst`  out  abits  live address registers.
- `remaining`  out  lbits  words not yet completed.
- `m_req`  out  1  toggle request to the arbitrator.
- `m_ack`  in  1  toggle acknowledge; the access is complete when `m_ack`==`m_req`.
- `m_we`, `m_a`, `m_d`  out  1/abits/dbits  access descriptor; held stable while an access is pending.
- `m_q`  in  dbits  read data; valid in the first cycle `m_ack`==`m_req`.

## Operation
- States: IDLE, RD_SRC, RD_DST, WR_DST, WR_SRC, ADV, FIN.
- Reset values:
  - State is IDLE.
  - `m_req`, `m_we`, `m_a`, `m_d` are 0.
  - `busy`, `done`, `mismatch` are 0.
  - `cur_src`, `cur_dst`, `remaining` are 0.
  - Reset is legal mid-transfer and aborts the transfer with no completion pulse.
  - The arbitrator must be reset in the same cycle, because its ack state returns to 0 together with `m_req`.
- Accepting a command (IDLE with `start`=1):
  - Latch the addresses, the fix bits, `op` and `fill_d`.
  - `remaining` <= `len`, `busy` <= 1, `mismatch` <= 0.
  - Go to the first access state of the op.
- Access states:
  - Entering any access state toggles `m_req` and drives `m_we`/`m_a`/`m_d` on the same edge.
  - The engine stays in the state until `m_ack`==`m_req`, then moves to the next state, capturing `m_q` if the access is a read.
- Per-word sequences:
  - COPY: RD_SRC (A<=`m_q`), then WR_DST(A), then ADV.
  - FILL: WR_DST(`fill_d`), then ADV.
  - VERIFY: RD_SRC (A), then RD_DST (B), then compare.
    - A≠B: `mismatch`<=1, go to FIN without ADV. Addresses point at the failing word and `remaining` still counts it.
    - A=B: go to ADV.
  - SWAP: RD_SRC (A), RD_DST (B), WR_DST(A), WR_SRC(B), then ADV.
- ADV (one cycle):
  - `cur_src` += !`src_fix`, `cur_dst` += !`dst_fix`; both wrap modulo 2^abits.
  - `remaining` -= 1, wrapping modulo 2^lbits.
  - If `remaining` was 1, go to FIN; otherwise go to the first access state. `len`=0 therefore runs 2^lbits words.
- FIN (one cycle): `done`=1, `busy` goes 0 at the same edge that leaves FIN, then IDLE.
- `start` while busy is ignored, with no latching and no effect on the transfer.
- `m_req` never toggles while an access is pending.

## Timing
- `start` at edge 0 makes the first `m_req` toggle at edge 1. `busy` is 1 from edge 1.
- The access issued at edge n completes in the first cycle with `m_ack`==`m_req`, at earliest cycle n+1 with an immediate-acking slave. The next state is entered at the end of that cycle.
- Cycles per word with zero-wait memory:
  - COPY 5 (2 accesses × 2 + ADV).
  - FILL 3.
  - VERIFY 5.
  - SWAP 9.
  - Each memory wait cycle adds 1.
- The FIN cycle follows the last ADV. `done` lasts exactly one cycle and coincides with the last `busy`=1 cycle.

## Test plan
- COPY, `src_a`=0x000010, `dst_a`=0x020000, `len`=4, mem[0x10..0x13]=11,22,33,44, zero-wait slave:
  - mem[0x20000..0x20003]=11,22,33,44.
  - 8 accesses, alternating read and write.
  - `done` 21 cycles after `start`.
  - `cur_src`=0x14, `remaining`=0.
- FILL with `dst_fix`=1, `dst_a`=0x100, `len`=3, `fill_d`=0xA5:
  - Three writes all to 0x100.
  - `cur_dst`=0x100 at end.
- VERIFY, `len`=5, with a difference at word 2:
  - `mismatch`=1 and `done` pulse after 6 reads.
  - `cur_src`=`src_a`+2, `remaining`=3.
  - The next `start` clears `mismatch`.
- SWAP, 2 words, src=(01,02), dst=(F1,F2):
  - Contents exchanged.
  - Access order per word is R src, R dst, W dst, W src.
- `len`=0, `lbits` reduced to 4 in the bench, `src_a`=0xFFFFFE:
  - 16 words transferred.
  - `cur_src` wraps through 0xFFFFFF to 0x00000E.
- Random 0–5 cycle ack delays, `start` pulses while busy, and `reset_n`=0 mid-SWAP:
  - `m_a` is stable while an access is pending.
  - Ignored starts have no effect.
  - After the reset, every output is at its reset value the next cycle and no `done` pulse occurs.
